// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: freezes the register file and the four pipeline latches on i_start,
// then streams HDR, LEN_LO, LEN_HI, the snapshot bytes and an XOR checksum into the UART TX FIFO.
module debug_dump_tx #(
    parameter int         SIZE          = 32,
    parameter int         NUM_REGISTERS = 32,
    parameter int         IF_ID_SIZE    = 32,
    parameter int         ID_EX_SIZE    = 129,
    parameter int         EX_MEM_SIZE   = 77,
    parameter int         MEM_WB_SIZE   = 71,
    parameter logic [7:0] HDR_BYTE      = 8'hA5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [NUM_REGISTERS*SIZE-1:0] i_registers,
    input  logic [IF_ID_SIZE-1:0]         i_if_id,
    input  logic [ID_EX_SIZE-1:0]         i_id_ex,
    input  logic [EX_MEM_SIZE-1:0]        i_ex_mem,
    input  logic [MEM_WB_SIZE-1:0]        i_mem_wb,
    input  logic                          i_tx_full,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_wr,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int SNAP_BITS = NUM_REGISTERS*SIZE + IF_ID_SIZE + ID_EX_SIZE + EX_MEM_SIZE + MEM_WB_SIZE;
    localparam int NB        = (SNAP_BITS + 7) / 8;
    localparam int CNT_W     = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [15:0]      LEN      = 16'(NB);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CKSUM,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NB*8-1:0]  r_snap;
    logic [7:0]       r_cksum;
    logic [CNT_W-1:0] r_cnt;
    logic [NB*8-1:0]  w_snap;

    // Registers sit in the LSBs; the unused top bits of the last byte stay zero.
    always_comb begin
        w_snap                = '0;
        w_snap[SNAP_BITS-1:0] = {i_mem_wb, i_ex_mem, i_id_ex, i_if_id, i_registers};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_snap    <= '0;
            r_cksum   <= '0;
            r_cnt     <= '0;
            o_tx_data <= '0;
            o_tx_wr   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_tx_wr <= 1'b0;
            o_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_snap  <= w_snap;
                        r_cksum <= '0;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!i_tx_full) begin
                        o_tx_wr   <= 1'b1;
                        o_tx_data <= HDR_BYTE;
                        r_state   <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (!i_tx_full) begin
                        o_tx_wr   <= 1'b1;
                        o_tx_data <= LEN[7:0];
                        r_state   <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (!i_tx_full) begin
                        o_tx_wr   <= 1'b1;
                        o_tx_data <= LEN[15:8];
                        r_state   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // The snapshot shifts down a byte per write, so the next byte is always at [7:0].
                    if (!i_tx_full) begin
                        o_tx_wr   <= 1'b1;
                        o_tx_data <= r_snap[7:0];
                        r_cksum   <= r_cksum ^ r_snap[7:0];
                        r_snap    <= r_snap >> 8;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_CKSUM;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_CKSUM: begin
                    if (!i_tx_full) begin
                        o_tx_wr   <= 1'b1;
                        o_tx_data <= r_cksum;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: frames are captured from the FIFO-side strobes and
// compared against the snapshot taken from the inputs at the moment of each start pulse.
module tb_debug_dump_tx;

    localparam int SIZE  = 32;
    localparam int NREG  = 32;
    localparam int IFW   = 32;
    localparam int IDW   = 129;
    localparam int EXW   = 77;
    localparam int MWW   = 71;
    localparam int T     = NREG*SIZE + IFW + IDW + EXW + MWW;
    localparam int NB    = 167;
    localparam int FRAME = NB + 4;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_start;
    logic [NREG*SIZE-1:0] i_registers;
    logic [IFW-1:0]       i_if_id;
    logic [IDW-1:0]       i_id_ex;
    logic [EXW-1:0]       i_ex_mem;
    logic [MWW-1:0]       i_mem_wb;
    logic                 i_tx_full;
    logic [7:0]           o_tx_data;
    logic                 o_tx_wr;
    logic                 o_busy;
    logic                 o_done;

    debug_dump_tx dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_registers (i_registers),
        .i_if_id     (i_if_id),
        .i_id_ex     (i_id_ex),
        .i_ex_mem    (i_ex_mem),
        .i_mem_wb    (i_mem_wb),
        .i_tx_full   (i_tx_full),
        .o_tx_data   (o_tx_data),
        .o_tx_wr     (o_tx_wr),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO-side monitor, sampled on the falling edge.
    int         cyc         = 0;
    int         busy_cycles = 0;
    int         done_cnt    = 0;
    int         done_cyc    = 0;
    logic [7:0] cap[$];
    int         wr_cyc[$];

    always @(negedge i_clk) begin
        cyc <= cyc + 1;
        if (o_tx_wr) begin
            cap.push_back(o_tx_data);
            wr_cyc.push_back(cyc);
        end
        if (o_busy) busy_cycles <= busy_cycles + 1;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] cap_at(input int idx);
        if (idx < cap.size()) return cap[idx];
        return 8'h00;
    endfunction

    function automatic int wc_at(input int idx);
        if (idx < wr_cyc.size()) return wr_cyc[idx];
        return -1000;
    endfunction

    function automatic logic [NB*8-1:0] cur_snap();
        logic [NB*8-1:0] s;
        s        = '0;
        s[T-1:0] = {i_mem_wb, i_ex_mem, i_id_ex, i_if_id, i_registers};
        return s;
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic clear_inputs();
        i_registers = '0;
        i_if_id     = '0;
        i_id_ex     = '0;
        i_ex_mem    = '0;
        i_mem_wb    = '0;
    endtask

    task automatic set_random();
        for (int k = 0; k < NREG; k++) i_registers[k*SIZE +: SIZE] = $urandom;
        i_if_id  = $urandom;
        i_id_ex  = IDW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        i_ex_mem = EXW'({$urandom, $urandom, $urandom});
        i_mem_wb = MWW'({$urandom, $urandom, $urandom});
    endtask

    task automatic wait_done(input int base, input string tag);
        int k;
        k = 0;
        while (done_cnt == base && k < 500) begin
            tick(1);
            k++;
        end
        check({tag, "_done_seen"}, done_cnt - base, 1);
        tick(3);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int seen;
        int k;
        seen = 0;
        k    = 0;
        while (seen < n && k < 500) begin
            tick(1);
            if (o_tx_wr) seen++;
            k++;
        end
        check({tag, "_writes_reached"}, seen, n);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [NB*8-1:0] snap);
        logic [7:0] e;
        logic [7:0] ck;
        int         nbad;
        ck   = 8'h00;
        nbad = 0;
        check({tag, "_frame_len"}, cap.size() - base, FRAME);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 0) e = 8'hA5;
            else if (i == 1) e = 8'(NB);
            else if (i == 2) e = 8'(NB >> 8);
            else if (i < FRAME - 1) begin
                e  = snap[(i-3)*8 +: 8];
                ck = ck ^ e;
            end else e = ck;
            if (i >= cap.size() - base || cap_at(base + i) !== e) nbad++;
        end
        check({tag, "_frame_bytes_bad"}, nbad, 0);
    endtask

    initial begin
        int              b;
        int              db;
        int              bb;
        int              hw;
        int              sz;
        logic [NB*8-1:0] snap_a;

        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_tx_full = 1'b0;
        clear_inputs();
        tick(3);
        check("rst_tx_wr", 32'(o_tx_wr), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_tx_data", 32'(o_tx_data), 0);

        // A start raised together with reset must not launch a frame.
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(1);
        check("rst_start_busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        tick(3);
        check("idle_no_wr", cap.size(), 0);
        check("idle_busy", 32'(o_busy), 0);

        // All-zero snapshot.
        b = cap.size(); db = done_cnt; bb = busy_cycles;
        snap_a = cur_snap();
        pulse_start();
        wait_done(db, "zero");
        check_frame("zero", b, snap_a);
        check("zero_hdr", 32'(cap_at(b)), 32'hA5);
        check("zero_len_lo", 32'(cap_at(b + 1)), 32'hA7);
        check("zero_len_hi", 32'(cap_at(b + 2)), 32'h00);
        check("zero_cksum", 32'(cap_at(b + FRAME - 1)), 32'h00);
        check("zero_wr_span", wc_at(b + FRAME - 1) - wc_at(b), FRAME - 1);
        check("zero_done_gap", done_cyc - wc_at(b + FRAME - 1), 1);
        check("zero_busy_cycles", busy_cycles - bb, NB + 5);
        check("zero_busy_after", 32'(o_busy), 0);

        // Register 1 = 0xFF.
        clear_inputs();
        i_registers[1*SIZE +: SIZE] = 32'h0000_00FF;
        b = cap.size(); db = done_cnt;
        snap_a = cur_snap();
        pulse_start();
        wait_done(db, "reg1");
        check_frame("reg1", b, snap_a);
        check("reg1_byte4", 32'(cap_at(b + 3 + 4)), 32'hFF);
        check("reg1_byte5", 32'(cap_at(b + 3 + 5)), 32'h00);
        check("reg1_cksum", 32'(cap_at(b + FRAME - 1)), 32'hFF);

        // IF/ID = 0x12345678.
        clear_inputs();
        i_if_id = 32'h1234_5678;
        b = cap.size(); db = done_cnt;
        snap_a = cur_snap();
        pulse_start();
        wait_done(db, "ifid");
        check_frame("ifid", b, snap_a);
        check("ifid_b128", 32'(cap_at(b + 3 + 128)), 32'h78);
        check("ifid_b129", 32'(cap_at(b + 3 + 129)), 32'h56);
        check("ifid_b130", 32'(cap_at(b + 3 + 130)), 32'h34);
        check("ifid_b131", 32'(cap_at(b + 3 + 131)), 32'h12);
        check("ifid_cksum", 32'(cap_at(b + FRAME - 1)), 32'h08);

        // FIFO full for 5 cycles while payload byte 10 is pending.
        set_random();
        b = cap.size(); db = done_cnt;
        snap_a = cur_snap();
        pulse_start();
        wait_writes(13, "full");
        i_tx_full = 1'b1;
        hw = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (o_tx_wr) hw++;
        end
        i_tx_full = 1'b0;
        check("full_hold_writes", hw, 0);
        wait_done(db, "full");
        check_frame("full", b, snap_a);
        check("full_byte10", 32'(cap_at(b + 13)), 32'(snap_a[10*8 +: 8]));
        check("full_byte10_gap", wc_at(b + 13) - wc_at(b + 12), 6);

        // Inputs change and a second start arrives mid-frame.
        set_random();
        b = cap.size(); db = done_cnt;
        snap_a = cur_snap();
        pulse_start();
        tick(20);
        set_random();
        pulse_start();
        wait_done(db, "restart");
        tick(30);
        check_frame("restart", b, snap_a);
        check("restart_done_count", done_cnt - db, 1);

        // Reset after 50 writes, then a fresh frame.
        set_random();
        b = cap.size();
        pulse_start();
        wait_writes(50, "abort");
        i_rst = 1'b1;
        tick(1);
        check("abort_tx_wr", 32'(o_tx_wr), 0);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_done", 32'(o_done), 0);
        i_rst = 1'b0;
        sz = cap.size();
        tick(10);
        check("abort_partial_len", sz - b, 50);
        check("abort_no_more_wr", cap.size() - sz, 0);
        check("abort_busy_idle", 32'(o_busy), 0);

        set_random();
        b = cap.size(); db = done_cnt;
        snap_a = cur_snap();
        pulse_start();
        wait_done(db, "fresh");
        check_frame("fresh", b, snap_a);
        check("fresh_hdr", 32'(cap_at(b)), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
